// File: rtl/mix_gain_sequencer.sv
// Mix gain sequencer: ramps the reverb wet/dry gains toward host targets by at most STEP per
// frame and programs them, plus the mixer soft-reset opcodes, through an APB master port.
module mix_gain_sequencer #(
    parameter int unsigned             DATA_WIDTH = 24,
    parameter logic [DATA_WIDTH-1:0]   STEP       = 24'h000800,
    parameter logic [DATA_WIDTH-1:0]   INIT_WET   = 24'h000000,
    parameter logic [DATA_WIDTH-1:0]   INIT_DRY   = 24'h7FFFFF,
    parameter logic [31:0]             APB_ADDR   = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    input  logic [DATA_WIDTH-1:0] cfg_wet,
    input  logic [DATA_WIDTH-1:0] cfg_dry,
    output logic                  cfg_ready,
    input  logic                  frame_tick,
    input  logic                  soft_rst_req,
    output logic [31:0]           m_apb_paddr,
    output logic                  m_apb_psel,
    output logic                  m_apb_penable,
    output logic                  m_apb_pwrite,
    output logic [31:0]           m_apb_pwdata,
    input  logic                  m_apb_pready,
    input  logic                  m_apb_pslverr,
    output logic [DATA_WIDTH-1:0] cur_wet,
    output logic [DATA_WIDTH-1:0] cur_dry,
    output logic                  busy,
    output logic                  err
);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_CALC, S_SETUP, S_ACCESS, S_NEXT, S_SRST} state_t;

    typedef struct packed {
        logic [2:0]            op;
        logic [DATA_WIDTH-1:0] gain;
    } item_t;

    localparam logic [2:0] OP_WET     = 3'b001;
    localparam logic [2:0] OP_DRY     = 3'b010;
    localparam logic [2:0] OP_RST_SET = 3'b111;
    localparam logic [2:0] OP_RST_CLR = 3'b110;

    localparam logic [DATA_WIDTH-1:0]        GAIN_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH:0]   STEP_S   = $signed({1'b0, STEP});

    state_t                state;
    logic [DATA_WIDTH-1:0] tgt_wet, tgt_dry;
    logic                  tick_pending, srst_pending;
    logic [2:0]            idx, len;
    item_t                 list      [4];
    item_t                 load_list [4];
    logic [2:0]            load_len;
    logic [DATA_WIDTH-1:0] nxt_wet, nxt_dry;

    function automatic logic [DATA_WIDTH-1:0] clamp(input logic [DATA_WIDTH-1:0] v);
        return v[DATA_WIDTH-1] ? GAIN_MAX : v;
    endfunction

    // One frame of ramp: land on the target when within STEP, else move a full STEP toward it.
    function automatic logic [DATA_WIDTH-1:0] ramp(input logic [DATA_WIDTH-1:0] cur,
                                                   input logic [DATA_WIDTH-1:0] tgt);
        logic signed [DATA_WIDTH:0] diff;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (diff > STEP_S)       return cur + STEP;
        else if (diff < -STEP_S) return cur - STEP;
        else                     return tgt;
    endfunction

    function automatic logic [31:0] pack(input item_t it);
        return {{(29-DATA_WIDTH){1'b0}}, it.gain, it.op};
    endfunction

    assign m_apb_paddr = APB_ADDR;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        load_list = '{default: '0};
        load_len  = 3'd0;
        nxt_wet   = ramp(cur_wet, tgt_wet);
        nxt_dry   = ramp(cur_dry, tgt_dry);
        case (state)
            S_INIT: begin
                load_list[0] = '{op: OP_WET, gain: INIT_WET};
                load_list[1] = '{op: OP_DRY, gain: INIT_DRY};
                load_len     = 3'd2;
            end
            S_SRST: begin
                load_list[0] = '{op: OP_RST_SET, gain: '0};
                load_list[1] = '{op: OP_RST_CLR, gain: '0};
                load_list[2] = '{op: OP_WET, gain: cur_wet};
                load_list[3] = '{op: OP_DRY, gain: cur_dry};
                load_len     = 3'd4;
            end
            S_CALC: begin
                if (nxt_wet != cur_wet) begin
                    load_list[0] = '{op: OP_WET, gain: nxt_wet};
                    load_list[1] = '{op: OP_DRY, gain: nxt_dry};
                    load_len     = (nxt_dry != cur_dry) ? 3'd2 : 3'd1;
                end else if (nxt_dry != cur_dry) begin
                    load_list[0] = '{op: OP_DRY, gain: nxt_dry};
                    load_len     = 3'd1;
                end
            end
            default: ;
        endcase
    end

    // NOTE: the write list is pure datapath, always reloaded before it is read, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == S_INIT || state == S_SRST || state == S_CALC) list <= load_list;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_INIT;
            m_apb_psel    <= 1'b0;
            m_apb_penable <= 1'b0;
            m_apb_pwrite  <= 1'b0;
            m_apb_pwdata  <= '0;
            cur_wet       <= INIT_WET;
            cur_dry       <= INIT_DRY;
            tgt_wet       <= INIT_WET;
            tgt_dry       <= INIT_DRY;
            busy          <= 1'b1;
            cfg_ready     <= 1'b0;
            err           <= 1'b0;
            tick_pending  <= 1'b0;
            srst_pending  <= 1'b0;
            idx           <= 3'd0;
            len           <= 3'd0;
        end else begin
            if (cfg_valid && cfg_ready) begin
                tgt_wet <= clamp(cfg_wet);
                tgt_dry <= clamp(cfg_dry);
            end
            // Requests arriving mid-sequence are parked; a second parked tick is an overrun.
            if (state != S_IDLE) begin
                if (frame_tick) begin
                    if (tick_pending) err <= 1'b1;
                    tick_pending <= 1'b1;
                end
                if (soft_rst_req) srst_pending <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (soft_rst_req || srst_pending) begin
                        state     <= S_SRST;
                        busy      <= 1'b1;
                        cfg_ready <= 1'b0;
                        if (frame_tick) begin
                            if (tick_pending) err <= 1'b1;
                            tick_pending <= 1'b1;
                        end
                    end else if (frame_tick || tick_pending) begin
                        state        <= S_CALC;
                        busy         <= 1'b1;
                        tick_pending <= frame_tick && tick_pending;
                    end
                end
                S_INIT, S_SRST, S_CALC: begin
                    idx <= 3'd0;
                    len <= load_len;
                    if (state == S_SRST) srst_pending <= soft_rst_req;
                    if (load_len == 3'd0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state        <= S_SETUP;
                        m_apb_psel   <= 1'b1;
                        m_apb_pwrite <= 1'b1;
                        m_apb_pwdata <= pack(load_list[0]);
                    end
                end
                S_SETUP: begin
                    m_apb_penable <= 1'b1;
                    state         <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (m_apb_pready) begin
                        m_apb_psel    <= 1'b0;
                        m_apb_penable <= 1'b0;
                        m_apb_pwrite  <= 1'b0;
                        if (m_apb_pslverr) err <= 1'b1;
                        case (list[idx[1:0]].op)
                            OP_WET:  cur_wet <= list[idx[1:0]].gain;
                            OP_DRY:  cur_dry <= list[idx[1:0]].gain;
                            default: ;
                        endcase
                        idx   <= idx + 3'd1;
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (idx < len) begin
                        state        <= S_SETUP;
                        m_apb_psel   <= 1'b1;
                        m_apb_pwrite <= 1'b1;
                        m_apb_pwdata <= pack(list[idx[1:0]]);
                    end else begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        cfg_ready <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
